// File: rtl/gpio_bridge_pkg.sv
// Shared field map, opcodes and FSM encoding for the MicroBlaze GPIO command bridge.
package gpio_bridge_pkg;

    // GPO command word fields
    localparam int unsigned REQ_BIT  = 31;
    localparam int unsigned OPC_MSB  = 30;
    localparam int unsigned OPC_LSB  = 28;
    localparam int unsigned ADDR_MSB = 27;
    localparam int unsigned ADDR_LSB = 24;
    localparam int unsigned OPC_W    = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned WDATA_W  = 24;

    // GPI response word fields
    localparam int unsigned ACK_BIT = 31;
    localparam int unsigned ERR_BIT = 30;
    localparam int unsigned TO_BIT  = 29;

    localparam logic [OPC_W-1:0] OP_NOP    = 3'd0;
    localparam logic [OPC_W-1:0] OP_WRITE  = 3'd1;
    localparam logic [OPC_W-1:0] OP_RDREG  = 3'd2;
    localparam logic [OPC_W-1:0] OP_RDSTAT = 3'd3;
    localparam logic [OPC_W-1:0] OP_CLEAR  = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StAck
    } state_e;

endpackage

// File: rtl/gpio_bridge_regfile.sv
// Control register bank: one write port, synchronous clear-all and an asynchronous read mux.
module gpio_bridge_regfile
    import gpio_bridge_pkg::*;
#(
    parameter int unsigned NB_DATA = 24,
    parameter int unsigned NB_REGS = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic                       clr_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [NB_DATA-1:0]         wr_data_i,
    input  logic [ADDR_W-1:0]          rd_addr_i,
    output logic [NB_DATA-1:0]         rd_data_o,
    output logic [NB_REGS*NB_DATA-1:0] regs_o
);

    logic [NB_DATA-1:0] regs_q [NB_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NB_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (clr_i) begin
            for (int k = 0; k < NB_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we_i) begin
            for (int k = 0; k < NB_REGS; k++) begin
                if (32'(wr_addr_i) == k) begin
                    regs_q[k] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NB_REGS; k++) begin
            if (32'(rd_addr_i) == k) begin
                rd_data_o = regs_q[k];
            end
        end
    end

    for (genvar g = 0; g < NB_REGS; g++) begin : g_pack
        assign regs_o[g*NB_DATA +: NB_DATA] = regs_q[g];
    end

endmodule

// File: rtl/gpio_cmd_bridge.sv
// Decodes MicroBlaze GPO command words into register bank accesses and answers on GPI.
// Define GPIO_BRIDGE_TIMEOUT_EN to abandon an ACK that is held longer than TIMEOUT_CYCLES.
module gpio_cmd_bridge
    import gpio_bridge_pkg::*;
#(
    parameter int unsigned NB_GPIOS       = 32,
    parameter int unsigned NB_DATA        = 24,
    parameter int unsigned NB_REGS        = 16,
    parameter int unsigned NB_STAT        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                       i_clk100,
    input  logic                       i_reset,
    input  logic [NB_GPIOS-1:0]        i_gpo,
    output logic [NB_GPIOS-1:0]        o_gpi,
    input  logic [NB_STAT*NB_DATA-1:0] i_status,
    output logic [NB_REGS*NB_DATA-1:0] o_regs,
    output logic                       o_wr_pulse,
    output logic [ADDR_W-1:0]          o_wr_addr
);

    state_e             state_q, state_d;
    logic               req_q, armed_q, rise;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d;
    logic [NB_DATA-1:0] rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               rf_we, rf_clr;
    logic [NB_DATA-1:0] rf_rd_data, stat_word;
    logic               stat_oob;
    logic               timeout_bit, to_expire;
    logic [31:0]        gpi_word;

    // armed_q masks the first cycle after reset so a req already high is not taken as a rise
    assign rise = i_gpo[REQ_BIT] & ~req_q & armed_q;

    always_ff @(posedge i_clk100 or posedge i_reset) begin
        if (i_reset) begin
            req_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            req_q   <= i_gpo[REQ_BIT];
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        stat_word = '0;
        for (int k = 0; k < NB_STAT; k++) begin
            if (32'(addr_q) == k) begin
                stat_word = i_status[k*NB_DATA +: NB_DATA];
            end
        end
    end

    assign stat_oob = 32'(addr_q) >= NB_STAT;

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        rf_we      = 1'b0;
        rf_clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StExec;
                    opc_d   = i_gpo[OPC_MSB:OPC_LSB];
                    addr_d  = i_gpo[ADDR_MSB:ADDR_LSB];
                    wdata_d = i_gpo[NB_DATA-1:0];
                end
            end
            StExec: begin
                state_d = StAck;
                rdata_d = '0;
                err_d   = 1'b0;
                case (opc_q)
                    OP_NOP: ;
                    OP_WRITE: begin
                        rf_we      = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = addr_q;
                    end
                    OP_RDREG: rdata_d = rf_rd_data;
                    OP_RDSTAT: begin
                        if (stat_oob) begin
                            err_d = 1'b1;
                        end else begin
                            rdata_d = stat_word;
                        end
                    end
                    OP_CLEAR: begin
                        rf_clr     = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = '0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            StAck: begin
                if (!i_gpo[REQ_BIT] || to_expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk100 or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            opc_q      <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

`ifdef GPIO_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    assign to_expire = (state_q == StAck) && i_gpo[REQ_BIT] &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Sticky flag: cleared only when a command without error enters ACK
    always_ff @(posedge i_clk100 or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == StAck) ? cnt_q + CntW'(1) : '0;
            if (to_expire) begin
                timeout_q <= 1'b1;
            end else if (state_q == StExec && !err_d) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout_bit = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_expire          = 1'b0;
    assign timeout_bit        = 1'b0;
`endif

    gpio_bridge_regfile #(
        .NB_DATA (NB_DATA),
        .NB_REGS (NB_REGS)
    ) u_regfile (
        .clk_i     (i_clk100),
        .rst_i     (i_reset),
        .we_i      (rf_we),
        .clr_i     (rf_clr),
        .wr_addr_i (addr_q),
        .wr_data_i (wdata_q),
        .rd_addr_i (addr_q),
        .rd_data_o (rf_rd_data),
        .regs_o    (o_regs)
    );

    always_comb begin
        gpi_word                = '0;
        gpi_word[ACK_BIT]       = (state_q == StAck);
        gpi_word[ERR_BIT]       = err_q;
        gpi_word[TO_BIT]        = timeout_bit;
        gpi_word[WDATA_W-1:0]   = WDATA_W'(rdata_q);
    end

    assign o_gpi      = NB_GPIOS'(gpi_word);
    assign o_wr_pulse = wr_pulse_q;
    assign o_wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Directed bench for gpio_cmd_bridge; timeout cases build only with GPIO_BRIDGE_TIMEOUT_EN.
module tb_gpio_cmd_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  gpo = 32'h8000_0000;
    logic [31:0]  gpi;
    logic [95:0]  status = '0;
    logic [383:0] regs;
    logic         wr_pulse;
    logic [3:0]   wr_addr;

    int n_checks = 0;
    int n_errors = 0;

    gpio_cmd_bridge #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk100   (clk),
        .i_reset    (rst),
        .i_gpo      (gpo),
        .o_gpi      (gpi),
        .i_status   (status),
        .o_regs     (regs),
        .o_wr_pulse (wr_pulse),
        .o_wr_addr  (wr_addr)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_at(input int k);
        return 32'(regs[k*24 +: 24]);
    endfunction

    // Raise req with the given fields; returns in the first ACK cycle
    task automatic issue(input logic [31:0] word);
        gpo = word | 32'h8000_0000;
        tick();
        tick();
    endtask

    task automatic release_req();
        gpo[31] = 1'b0;
        tick();
    endtask

    initial begin
        // 1: reset with req held high
        repeat (3) tick();
        check("rst_gpi", gpi, 32'h0);
        check("rst_regs", 32'(|regs), 32'h0);
        check("rst_pulse", 32'(wr_pulse), 32'h0);
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_no_cmd", gpi, 32'h0);
        check("post_rst_regs", 32'(|regs), 32'h0);
        gpo = 32'h0;
        tick();

        // 2: write reg3
        gpo = 32'h1300_00AB;
        tick();
        check("wr_req_low", gpi, 32'h0);
        gpo = 32'h9300_00AB;
        tick();
        check("wr_exec_ack", gpi, 32'h0);
        check("wr_exec_pulse", 32'(wr_pulse), 32'h0);
        tick();
        check("wr_ack", gpi, 32'h8000_0000);
        check("wr_pulse", 32'(wr_pulse), 32'h1);
        check("wr_reg3", reg_at(3), 32'h0000_00AB);
        check("wr_addr", 32'(wr_addr), 32'h3);
        tick();
        check("wr_pulse_1cyc", 32'(wr_pulse), 32'h0);
        check("wr_ack_hold", gpi, 32'h8000_0000);
        gpo = 32'h1300_00AB;
        tick();
        check("wr_ack_drop", gpi, 32'h0);

        // 3: read back reg3
        issue(32'h2300_0000);
        check("rdreg3", gpi, 32'h8000_00AB);
        check("rdreg3_nopulse", 32'(wr_pulse), 32'h0);
        check("rdreg3_keep", reg_at(3), 32'h0000_00AB);
        release_req();
        check("rdreg3_hold", gpi, 32'h0000_00AB);

        // 4: status reads, including both sides of the address limit
        status = {24'hFEDCBA, 24'h654321, 24'h123456, 24'h0A0B0C};
        issue(32'h3100_0000);
        check("rdstat1", gpi, 32'h8012_3456);
        release_req();
        issue(32'h3300_0000);
        check("rdstat3", gpi, 32'h80FE_DCBA);
        release_req();
        issue(32'h3400_0000);
        check("rdstat4_err", gpi, 32'hC000_0000);
        release_req();
        issue(32'h3500_0000);
        check("rdstat5_err", gpi, 32'hC000_0000);
        release_req();
        issue(32'h0000_0000);
        check("nop", gpi, 32'h8000_0000);
        release_req();

        // 5: invalid opcode, then clear
        issue(32'h1755_AA33);
        check("wr_reg7", reg_at(7), 32'h0055_AA33);
        release_req();
        issue(32'h2700_0000);
        check("rdreg7", gpi, 32'h8055_AA33);
        release_req();
        issue(32'h6300_0012);
        check("bad_op_err", gpi, 32'hC000_0000);
        check("bad_op_reg3", reg_at(3), 32'h0000_00AB);
        check("bad_op_nopulse", 32'(wr_pulse), 32'h0);
        release_req();
        issue(32'h4500_0000);
        check("clr_ack", gpi, 32'h8000_0000);
        check("clr_regs", 32'(|regs), 32'h0);
        check("clr_pulse", 32'(wr_pulse), 32'h1);
        check("clr_addr", 32'(wr_addr), 32'h0);
        tick();
        check("clr_pulse_1cyc", 32'(wr_pulse), 32'h0);
        release_req();

        // req dropped during EXEC: completes, ack for exactly one cycle
        gpo = 32'h9200_0011;
        tick();
        gpo = 32'h1200_0011;
        tick();
        check("early_drop_ack", gpi, 32'h8000_0000);
        check("early_drop_reg2", reg_at(2), 32'h0000_0011);
        tick();
        check("early_drop_ack_gone", gpi, 32'h0);

        // field changes during ACK are ignored; held req does not restart
        issue(32'h1100_0022);
        gpo = 32'h91FF_FFFF;
        repeat (3) tick();
        check("ack_fields_reg1", reg_at(1), 32'h0000_0022);
        check("ack_fields_gpi", gpi, 32'h8000_0000);
        check("ack_fields_nopulse", 32'(wr_pulse), 32'h0);
        release_req();

        // reset mid-command aborts with no partial write
        gpo = 32'h9400_0077;
        tick();
        #1 rst = 1'b1;
        #1;
        check("abort_gpi", gpi, 32'h0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("abort_reg4", reg_at(4), 32'h0);
        check("abort_no_rise", gpi, 32'h0);
        release_req();
        issue(32'h1400_0077);
        check("post_abort_wr", reg_at(4), 32'h0000_0077);
        release_req();

`ifdef GPIO_BRIDGE_TIMEOUT_EN
        begin
            int ack_cycles = 0;
            issue(32'h1100_0005);
            for (int i = 0; i < 40; i++) begin
                if (gpi[31]) ack_cycles++;
                tick();
            end
            check("to_ack_cycles", 32'(ack_cycles), 32'd16);
            check("to_gpi", gpi, 32'h2000_0000);
            release_req();
            check("to_sticky", gpi, 32'h2000_0000);
            issue(32'h2100_0000);
            check("to_cleared", gpi, 32'h8000_0005);
            release_req();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
